// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART link types, constants and parity helper
package uart_pkg;

    localparam int BITS_PER_BYTE = 8;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        BYTE_PAR,
        FINAL_PAR,
        STOP,
        BREAK
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_BYTE_PAR,
        TX_FINAL_PAR,
        TX_STOP
    } tx_state_t;

    // Even parity: the parity bit equals the XOR of the covered bits.
    function automatic logic even_parity(input logic [63:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - reset-to-1 flop chain for the serial line
//   clk, rst : clock, asynchronous active-high reset
//   d        : raw serial input
//   q        : d delayed by SYNC_STAGES flops (combinational when 0)
module uart_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign q = d;
        end else begin : g_chain
            logic [SYNC_STAGES-1:0] ff;

            // Resets to 1 so a resetting link looks idle, not like a start bit.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ff <= '1;
                end else begin
                    ff[0] <= d;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        ff[i] <= ff[i-1];
                    end
                end
            end

            assign q = ff[SYNC_STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/rx_asm.sv
// rtl/rx_asm.sv - 1x-sampled UART receiver with even parity and valid/ready output
//   clk, rst        : clock, asynchronous active-high reset
//   rx_in           : serial line, idles high
//   parity_per_byte : 1 = parity after every byte plus a final parity bit
//   rx_data         : received word, held while rx_valid
//   rx_valid        : word available; rx_ready accepts it
//   parity_err      : qualifies rx_data, any parity check failed
//   frame_err       : qualifies rx_data, stop bit was 0
//   overrun         : sticky, a frame completed while the last word was unaccepted
//   busy            : receiver not idle
//   rx_done         : one-cycle pulse when the stop bit is sampled
module rx_asm
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  parity_per_byte,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy,
    output logic                  rx_done
);

    localparam int BCW = $clog2(DATA_WIDTH) + 1;
    localparam int BYW = $clog2(DATA_WIDTH / BITS_PER_BYTE) + 1;

    logic                  rx_s;
    rx_state_t             state;
    rx_state_t             state_nxt;
    logic [BCW-1:0]        bit_cnt;
    logic [BYW-1:0]        byte_cnt;
    logic [DATA_WIDTH-1:0] sr;
    logic                  acc;
    logic                  byte_par;
    logic                  err;
    logic                  mode;
    logic                  load;
    logic [2:0]            bit_lo;
    logic                  last_byte;

    uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_in),
        .q   (rx_s)
    );

    assign bit_lo    = 3'(bit_cnt);
    // Widen before multiplying so a narrow byte_cnt cannot wrap.
    assign last_byte = ((32'(byte_cnt) + 32'd1) * BITS_PER_BYTE) == DATA_WIDTH;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!rx_s) state_nxt = DATA;
            end
            DATA: begin
                if (mode && bit_lo == 3'd7) begin
                    state_nxt = BYTE_PAR;
                end else if (!mode && bit_cnt == BCW'(DATA_WIDTH - 1)) begin
                    state_nxt = FINAL_PAR;
                end
            end
            BYTE_PAR:  state_nxt = last_byte ? FINAL_PAR : DATA;
            FINAL_PAR: state_nxt = STOP;
            // A low stop bit parks in BREAK so a held-low line is not a new start.
            STOP:      state_nxt = rx_s ? IDLE : BREAK;
            BREAK: begin
                if (rx_s) state_nxt = IDLE;
            end
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        rx_done = (state == STOP);
        load    = (state == STOP) && (!rx_valid || rx_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
            sr       <= '0;
            acc      <= 1'b0;
            byte_par <= 1'b0;
            err      <= 1'b0;
            mode     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        assert (!(parity_per_byte && (DATA_WIDTH % BITS_PER_BYTE != 0)));
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                        acc      <= 1'b0;
                        byte_par <= 1'b0;
                        err      <= 1'b0;
                        mode     <= parity_per_byte;
                    end
                end
                DATA: begin
                    sr       <= {rx_s, sr[DATA_WIDTH-1:1]};
                    byte_par <= byte_par ^ rx_s;
                    bit_cnt  <= bit_cnt + BCW'(1);
                end
                BYTE_PAR: begin
                    err      <= err | (rx_s != byte_par);
                    acc      <= acc ^ byte_par;
                    byte_par <= 1'b0;
                    byte_cnt <= byte_cnt + BYW'(1);
                end
                FINAL_PAR: begin
                    // In per-byte mode acc holds the XOR of all byte parities.
                    err <= err | (rx_s != (mode ? acc : byte_par));
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // A new load wins over the handshake clearing rx_valid.
            if (load) begin
                rx_data    <= sr;
                rx_valid   <= 1'b1;
                parity_err <= err;
                frame_err  <= !rx_s;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (rx_done && !load) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rx_asm.sv
// tb/tb_rx_asm.sv - self-checking bench for rx_asm
module tb_rx_asm;

    localparam int W    = 16;
    localparam int SYNC = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rx_in = 1'b1;
    logic         parity_per_byte = 1'b0;
    logic         rx_ready = 1'b1;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         parity_err;
    logic         frame_err;
    logic         overrun;
    logic         busy;
    logic         rx_done;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    bit           line_b[$];
    bit           line_m[$];
    int           stop_at[$];
    logic [W-1:0] exp_d[$];
    bit           exp_pe[$];
    bit           exp_fe[$];

    always #5 clk = ~clk;

    rx_asm #(.DATA_WIDTH(W), .SYNC_STAGES(SYNC)) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_in           (rx_in),
        .parity_per_byte (parity_per_byte),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .parity_err      (parity_err),
        .frame_err       (frame_err),
        .overrun         (overrun),
        .busy            (busy),
        .rx_done         (rx_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_bit(input bit b, input bit m);
        line_b.push_back(b);
        line_m.push_back(m);
    endtask

    // Reference frame: start, data LSB first, a parity bit after each byte
    // in per-byte mode, a final parity bit (parity of the whole word in
    // either mode), stop. flip[k] corrupts the k-th parity bit on the line.
    // The mode input is only held for the first few bits and then inverted.
    task automatic add_frame(input logic [W-1:0] d, input bit mode, input bit [2:0] flip,
                             input bit stop, input int gap);
        int start;
        int pidx;
        bit perr;
        bit p;
        start = line_b.size();
        pidx  = 0;
        perr  = 0;
        line_b.push_back(1'b0);
        for (int i = 0; i < W; i++) begin
            line_b.push_back(d[i]);
            if (mode && (i % 8) == 7) begin
                p = ^d[i-7 +: 8];
                if (flip[pidx]) perr = 1;
                line_b.push_back(p ^ flip[pidx]);
                pidx++;
            end
        end
        p = ^d;
        if (flip[pidx]) perr = 1;
        line_b.push_back(p ^ flip[pidx]);
        line_b.push_back(stop);
        stop_at.push_back(line_b.size() - 1);
        exp_d.push_back(d);
        exp_pe.push_back(perr);
        exp_fe.push_back(!stop);
        for (int i = start; i < line_b.size(); i++) begin
            line_m.push_back((i - start < 4) ? mode : !mode);
        end
        for (int g = 0; g < gap; g++) push_bit(1'b1, 1'b0);
    endtask

    // Plays the queued line. In strict mode (rx_ready held high) every cycle
    // is checked: rx_done one edge after the stop bit edge, the word on
    // rx_valid one edge later, and rx_valid low everywhere else.
    task automatic play(input bit strict);
        bit exp_done;
        int kv;
        for (int i = 0; i < 4; i++) push_bit(1'b1, 1'b0);
        for (int i = 0; i < line_b.size(); i++) begin
            rx_in           = line_b[i];
            parity_per_byte = line_m[i];
            tick();
            if (strict) begin
                exp_done = 0;
                kv       = -1;
                foreach (stop_at[k]) begin
                    if (stop_at[k] + 1 == i) exp_done = 1;
                    if (stop_at[k] + 2 == i) kv = k;
                end
                check("rx_done", rx_done, exp_done);
                check("rx_valid", rx_valid, kv >= 0);
                if (kv >= 0) begin
                    check("rx_data", rx_data, exp_d[kv]);
                    check("parity_err", parity_err, exp_pe[kv]);
                    check("frame_err", frame_err, exp_fe[kv]);
                end
            end
        end
        if (strict) check("no_overrun", overrun, 0);
        line_b.delete();
        line_m.delete();
        stop_at.delete();
        exp_d.delete();
        exp_pe.delete();
        exp_fe.delete();
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", rx_done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_perr", parity_err, 0);
        check("rst_ferr", frame_err, 0);
        rst = 1'b0;
        tick();
        tick();
        check("idle_busy", busy, 0);

        // Directed frames: per-byte parity clean and corrupted, plain parity
        add_frame(16'h13F1, 1'b1, 3'b000, 1'b1, 2);
        add_frame(16'h13F1, 1'b1, 3'b001, 1'b1, 2);
        add_frame(16'h00A5, 1'b0, 3'b000, 1'b1, 1);
        add_frame(16'h5A5A, 1'b1, 3'b100, 1'b1, 0);
        add_frame(16'hFFFF, 1'b0, 3'b001, 1'b1, 0);
        play(1'b1);

        // Randomized back-to-back traffic
        for (int n = 0; n < 24; n++) begin
            add_frame(W'($urandom), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
                      1'b1, $urandom_range(0, 2));
        end
        play(1'b1);

        // Stop bit low followed by a held-low line, then a clean frame
        add_frame(16'h003C, 1'b0, 3'b000, 1'b0, 0);
        for (int i = 0; i < 5; i++) push_bit(1'b0, 1'b0);
        push_bit(1'b1, 1'b0);
        add_frame(W'($urandom), 1'b1, 3'b000, 1'b1, 0);
        play(1'b1);

        // Overrun: consumer stalled across two frames
        rx_ready = 1'b0;
        add_frame(16'h0011, 1'b0, 3'b000, 1'b1, 2);
        add_frame(16'h0022, 1'b1, 3'b010, 1'b1, 4);
        play(1'b0);
        check("ovr_valid", rx_valid, 1);
        check("ovr_data", rx_data, 16'h0011);
        check("ovr_perr", parity_err, 0);
        check("ovr_flag", overrun, 1);
        rx_ready = 1'b1;
        tick();
        check("ovr_drop", rx_valid, 0);
        check("ovr_sticky", overrun, 1);

        // Reset in the middle of a frame
        parity_per_byte = 1'b0;
        rx_in = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            rx_in = 1'($urandom_range(0, 1));
            tick();
        end
        check("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_valid", rx_valid, 0);
        check("arst_data", rx_data, 0);
        check("arst_overrun", overrun, 0);
        rx_in = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        add_frame(W'($urandom), 1'b1, 3'b000, 1'b1, 1);
        add_frame(W'($urandom), 1'b0, 3'b000, 1'b1, 0);
        play(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
